eth_gmii_tx: RTL and testbench

//  Gigabit Ethernet transmit framer: takes a byte-wide AXIS frame (dest MAC .. payload, no FCS)
//  and drives GMII TX with preamble, SFD, optional zero padding to minimum length, CRC32 FCS and
//  an enforced inter-packet gap. Sits after axis_packet_fifo_async in the eth_rxclk domain and

---
 rtl/eth_gmii_tx.sv | 193 +++++++++++++++++++
 tb/tb_eth_gmii_tx.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_tx.sv
// Gigabit Ethernet GMII transmit framer. It adds the preamble, SFD, optional zero padding,
// CRC32 FCS and the inter-packet gap around a byte-wide AXIS frame.
module eth_gmii_tx #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int ENABLE_PAD      = 1,
    parameter int GAP_CYCLES      = 12
) (
    input  logic       clk,
    input  logic       sresetn,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       tx_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_GAP
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME_BYTES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;
    logic        done_q, done_d;

    logic [10:0] byte_cnt_inc;
    logic [11:0] len_after_byte;
    logic [31:0] fcs_inv;
    logic [7:0]  fcs_byte;

    // Byte-serial reflected CRC32: the data byte enters LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_cnt_inc   = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign len_after_byte = {1'b0, byte_cnt_q} + 12'd1;
    assign fcs_inv        = ~crc_q;

    always_comb begin
        fcs_byte = fcs_inv[7:0];
        case (cnt_q[1:0])
            2'd0:    fcs_byte = fcs_inv[7:0];
            2'd1:    fcs_byte = fcs_inv[15:8];
            2'd2:    fcs_byte = fcs_inv[23:16];
            default: fcs_byte = fcs_inv[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        txd_d      = 8'h00;
        txen_d     = 1'b0;
        txer_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (axis_i_tvalid) begin
                    state_d    = S_PRE;
                    cnt_d      = 8'd0;
                    byte_cnt_d = 11'd0;
                    crc_d      = CRC_INIT;
                end
            end
            S_PRE: begin
                txen_d = 1'b1;
                txd_d  = 8'h55;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SFD: begin
                txen_d  = 1'b1;
                txd_d   = 8'hD5;
                state_d = S_DATA;
            end
            S_DATA: begin
                txen_d = 1'b1;
                // A missing byte mid-frame cannot be stalled on GMII; flag it as an error symbol.
                if (axis_i_tvalid) begin
                    txd_d      = axis_i_tdata;
                    crc_d      = crc_byte(crc_q, axis_i_tdata);
                    byte_cnt_d = byte_cnt_inc;
                    if (axis_i_tlast) begin
                        cnt_d = 8'd0;
                        if ((ENABLE_PAD != 0) && (len_after_byte < MIN_LEN)) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                        end
                    end
                end else begin
                    txer_d = 1'b1;
                end
            end
            S_PAD: begin
                txen_d     = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc;
                if (len_after_byte >= MIN_LEN) begin
                    cnt_d   = 8'd0;
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                txen_d = 1'b1;
                txd_d  = fcs_byte;
                if (cnt_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            byte_cnt_q <= 11'd0;
            crc_q      <= CRC_INIT;
            txd_q      <= 8'h00;
            txen_q     <= 1'b0;
            txer_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            txen_q     <= txen_d;
            txer_q     <= txer_d;
            done_q     <= done_d;
        end
    end

    assign axis_i_tready = (state_q == S_DATA);
    assign tx_busy       = (state_q != S_IDLE);
    assign gmii_txd      = txd_q;
    assign gmii_txen     = txen_q;
    assign gmii_txer     = txer_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_eth_gmii_tx.sv
// Randomized bench for eth_gmii_tx. It uses one padding and one non-padding instance and
// compares each captured GMII stream with a frame-level reference model.
module tb_eth_gmii_tx;

    localparam int PRE_N = 7;
    localparam int MIN_N = 60;
    localparam int GAP_N = 12;
    localparam int GAP_CAP = 40;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] word_q_t[$];

    logic       clk = 1'b0;
    logic       sresetn = 1'b0;
    logic       sel = 1'b0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic [7:0] tdata = 8'h00;

    logic       a_tready, a_txen, a_txer, a_busy, a_done;
    logic [7:0] a_txd;
    logic       b_tready, b_txen, b_txer, b_busy, b_done;
    logic [7:0] b_txd;
    logic       m_tready, m_txen, m_txer, m_busy, m_done;
    logic [7:0] m_txd;

    int checks = 0;
    int failures = 0;

    eth_gmii_tx #(.PREAMBLE_BYTES(PRE_N), .MIN_FRAME_BYTES(MIN_N), .ENABLE_PAD(1), .GAP_CYCLES(GAP_N)) u_pad (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(a_tready), .axis_i_tvalid(tvalid & ~sel), .axis_i_tlast(tlast), .axis_i_tdata(tdata),
        .gmii_txd(a_txd), .gmii_txen(a_txen), .gmii_txer(a_txer), .tx_busy(a_busy), .frame_done(a_done)
    );

    eth_gmii_tx #(.PREAMBLE_BYTES(PRE_N), .MIN_FRAME_BYTES(MIN_N), .ENABLE_PAD(0), .GAP_CYCLES(GAP_N)) u_nopad (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(b_tready), .axis_i_tvalid(tvalid & sel), .axis_i_tlast(tlast), .axis_i_tdata(tdata),
        .gmii_txd(b_txd), .gmii_txen(b_txen), .gmii_txer(b_txer), .tx_busy(b_busy), .frame_done(b_done)
    );

    assign m_tready = sel ? b_tready : a_tready;
    assign m_txen   = sel ? b_txen   : a_txen;
    assign m_txer   = sel ? b_txer   : a_txer;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_done   = sel ? b_done   : a_done;
    assign m_txd    = sel ? b_txd    : a_txd;

    always #4 clk = ~clk;

    // Reference model: a plain bit-serial CRC32 (Ethernet FCS) over the whole message.
    function automatic logic [31:0] ref_fcs(input byte_q_t msg);
        logic [31:0] crc;
        logic fb;
        crc = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ msg[i][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        return ~crc;
    endfunction

    // Builds the expected {txer, txd} sequence for every txen-high cycle of one frame.
    function automatic void build_expected(input byte_q_t data, input bit pad, input int stall_at,
                                           input int stall_len, output word_q_t exp);
        byte_q_t body;
        logic [31:0] fcs;
        exp = {};
        body = data;
        if (pad) begin
            while (body.size() < MIN_N) body.push_back(8'h00);
        end
        for (int i = 0; i < PRE_N; i++) exp.push_back({1'b0, 8'h55});
        exp.push_back({1'b0, 8'hD5});
        for (int i = 0; i < body.size(); i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) exp.push_back({1'b1, 8'h00});
            end
            exp.push_back({1'b0, body[i]});
        end
        fcs = ref_fcs(body);
        for (int k = 0; k < 4; k++) exp.push_back({1'b0, fcs[8*k +: 8]});
    endfunction

    function automatic int first_diff(input word_q_t a, input word_q_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (a[i] !== b[i]) return i;
        end
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic logic [8:0] word_at(input word_q_t q, input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 9'h1FF;
    endfunction

    task automatic send_frame(input byte_q_t data, input int stall_at, input int stall_len, input bit release_bus);
        int i;
        int stalled;
        int guard;
        i = 0;
        stalled = 0;
        guard = 0;
        while (i < data.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (i == stall_at && stalled < stall_len) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                stalled++;
            end else begin
                tvalid = 1'b1;
                tdata  = data[i];
                tlast  = (i == data.size() - 1);
                if (m_tready === 1'b1) i++;
            end
        end
        if (release_bus) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic capture(output word_q_t got, output int done_idx, output int done_cnt,
                           output int rdy_cnt, output int gap, output bit timed_out);
        int guard;
        guard = 0;
        got = {};
        done_idx = -1;
        done_cnt = 0;
        rdy_cnt = 0;
        gap = 0;
        timed_out = 1'b0;
        while (m_txen !== 1'b1 && guard < 400) begin
            if (m_tready === 1'b1) rdy_cnt++;
            @(negedge clk);
            guard++;
        end
        if (m_txen !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        while (m_txen === 1'b1 && got.size() < 3000) begin
            if (m_done === 1'b1) begin
                done_cnt++;
                done_idx = got.size();
            end
            if (m_tready === 1'b1) rdy_cnt++;
            got.push_back({m_txer, m_txd});
            @(negedge clk);
        end
        while (m_txen !== 1'b1 && gap < GAP_CAP) begin
            if (m_tready === 1'b1) rdy_cnt++;
            if (m_done === 1'b1) done_cnt++;
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input bit use_b, input byte_q_t data, input int stall_at, input int stall_len,
                             output word_q_t got, output int done_idx, output int done_cnt,
                             output int rdy_cnt, output int gap, output bit timed_out);
        sel = use_b;
        fork
            send_frame(data, stall_at, stall_len, 1'b1);
            capture(got, done_idx, done_cnt, rdy_cnt, gap, timed_out);
        join
    endtask

    task automatic test_reset();
        sresetn = 1'b0;
        sel = 1'b0;
        tvalid = 1'b1;
        tdata = 8'hA5;
        tlast = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_txd, a_txen, a_txer, a_tready, a_busy, a_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_pad outputs got %h required 0", {a_txd, a_txen, a_txer, a_tready, a_busy, a_done});
        end
        checks++;
        if ({b_txd, b_txen, b_txer, b_tready, b_busy, b_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_nopad outputs got %h required 0", {b_txd, b_txen, b_txer, b_tready, b_busy, b_done});
        end
        tvalid = 1'b0;
        sresetn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_txen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset busy=%b txen=%b required 0 0", a_busy, a_txen);
        end
    endtask

    task automatic test_latency();
        int g;
        sel = 1'b0;
        tdata = 8'($urandom);
        tlast = 1'b1;
        tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (m_txen !== 1'b0 || m_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_cycle1 txen=%b busy=%b required 0 1", m_txen, m_busy);
        end
        @(negedge clk);
        checks++;
        if (m_txen !== 1'b1 || m_txd !== 8'h55) begin
            failures++;
            $display("[TB] FAIL latency_cycle2 txen=%b txd=%h required 1 55", m_txen, m_txd);
        end
        g = 0;
        while (m_tready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
        g = 0;
        while (m_busy === 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_drain busy=%b required 0", m_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_no_pad();
        byte_q_t data;
        word_q_t exp, got;
        int d_idx, d_cnt, rdy, gap, diff, n;
        bit to;
        logic [31:0] got_fcs;
        for (int t = 0; t < 2; t++) begin
            data = {};
            if (t == 0) begin
                for (int i = 0; i < 9; i++) data.push_back(8'h31 + 8'(i));
            end else begin
                n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) data.push_back(8'($urandom));
            end
            build_expected(data, 1'b0, -1, 0, exp);
            run_frame(1'b1, data, -1, 0, got, d_idx, d_cnt, rdy, gap, to);
            checks++;
            if (to) begin
                failures++;
                $display("[TB] FAIL nopad_timeout no txen within bound, frame len %0d", data.size());
            end
            diff = first_diff(got, exp);
            checks++;
            if (diff != -1) begin
                failures++;
                $display("[TB] FAIL nopad_stream len %0d idx %0d got %h required %h (sizes %0d/%0d)",
                         data.size(), diff, word_at(got, diff), word_at(exp, diff), got.size(), exp.size());
            end
            checks++;
            if (d_cnt != 1 || d_idx != exp.size() - 1) begin
                failures++;
                $display("[TB] FAIL nopad_done count %0d at %0d required 1 at %0d", d_cnt, d_idx, exp.size() - 1);
            end
            checks++;
            if (rdy != data.size() || gap != GAP_CAP) begin
                failures++;
                $display("[TB] FAIL nopad_ready_gap tready %0d gap %0d required %0d %0d", rdy, gap, data.size(), GAP_CAP);
            end
            if (t == 0) begin
                got_fcs = 32'h0;
                if (got.size() >= 4) begin
                    got_fcs = {got[got.size()-1][7:0], got[got.size()-2][7:0],
                               got[got.size()-3][7:0], got[got.size()-4][7:0]};
                end
                checks++;
                if (got_fcs !== 32'hCBF43926) begin
                    failures++;
                    $display("[TB] FAIL nopad_check_value fcs %h required cbf43926", got_fcs);
                end
            end
        end
    endtask

    task automatic test_pad();
        int lens[5];
        byte_q_t data;
        word_q_t exp, got;
        int d_idx, d_cnt, rdy, gap, diff;
        bit to;
        lens = '{14, 1, 59, 60, 61};
        lens[4] = $urandom_range(61, 120);
        foreach (lens[t]) begin
            data = {};
            for (int i = 0; i < lens[t]; i++) data.push_back(8'($urandom));
            build_expected(data, 1'b1, -1, 0, exp);
            run_frame(1'b0, data, -1, 0, got, d_idx, d_cnt, rdy, gap, to);
            checks++;
            if (to) begin
                failures++;
                $display("[TB] FAIL pad_timeout no txen within bound, frame len %0d", lens[t]);
            end
            diff = first_diff(got, exp);
            checks++;
            if (diff != -1) begin
                failures++;
                $display("[TB] FAIL pad_stream len %0d idx %0d got %h required %h (sizes %0d/%0d)",
                         lens[t], diff, word_at(got, diff), word_at(exp, diff), got.size(), exp.size());
            end
            checks++;
            if (d_cnt != 1 || d_idx != exp.size() - 1) begin
                failures++;
                $display("[TB] FAIL pad_done count %0d at %0d required 1 at %0d", d_cnt, d_idx, exp.size() - 1);
            end
            checks++;
            if (rdy != lens[t] || gap != GAP_CAP) begin
                failures++;
                $display("[TB] FAIL pad_ready_gap tready %0d gap %0d required %0d %0d", rdy, gap, lens[t], GAP_CAP);
            end
            if (t == 0) begin
                checks++;
                if (got.size() != 72) begin
                    failures++;
                    $display("[TB] FAIL pad_txen_cycles got %0d required 72", got.size());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t d1, d2;
        word_q_t e1, e2, g1, g2;
        int i1, c1, r1, gap1, i2, c2, r2, gap2;
        bit to1, to2;
        for (int i = 0; i < 64; i++) d1.push_back(8'($urandom));
        for (int i = 0; i < 64; i++) d2.push_back(8'($urandom));
        build_expected(d1, 1'b1, -1, 0, e1);
        build_expected(d2, 1'b1, -1, 0, e2);
        sel = 1'b0;
        fork
            begin
                send_frame(d1, -1, 0, 1'b0);
                send_frame(d2, -1, 0, 1'b1);
            end
            begin
                capture(g1, i1, c1, r1, gap1, to1);
                capture(g2, i2, c2, r2, gap2, to2);
            end
        join
        checks++;
        if (to1 || to2 || first_diff(g1, e1) != -1 || first_diff(g2, e2) != -1) begin
            failures++;
            $display("[TB] FAIL b2b_streams timeouts %0d/%0d diffs %0d/%0d required -1/-1",
                     to1, to2, first_diff(g1, e1), first_diff(g2, e2));
        end
        checks++;
        if (gap1 != GAP_N + 1) begin
            failures++;
            $display("[TB] FAIL b2b_gap got %0d required %0d", gap1, GAP_N + 1);
        end
        checks++;
        if (r1 != 64 || r2 != 64) begin
            failures++;
            $display("[TB] FAIL b2b_tready cycles %0d/%0d required 64/64", r1, r2);
        end
        checks++;
        if (c1 != 1 || c2 != 1 || gap2 != GAP_CAP) begin
            failures++;
            $display("[TB] FAIL b2b_done counts %0d/%0d gap2 %0d required 1/1 %0d", c1, c2, gap2, GAP_CAP);
        end
    endtask

    task automatic test_underrun();
        byte_q_t data;
        word_q_t exp, got;
        int d_idx, d_cnt, rdy, gap, diff, n, sa, sl;
        bit to;
        for (int t = 0; t < 2; t++) begin
            n  = (t == 0) ? $urandom_range(61, 90) : 10;
            sa = (t == 0) ? $urandom_range(1, n - 1) : 5;
            sl = (t == 0) ? 3 : $urandom_range(1, 4);
            data = {};
            for (int i = 0; i < n; i++) data.push_back(8'($urandom));
            build_expected(data, 1'b1, sa, sl, exp);
            run_frame(1'b0, data, sa, sl, got, d_idx, d_cnt, rdy, gap, to);
            diff = first_diff(got, exp);
            checks++;
            if (to || diff != -1) begin
                failures++;
                $display("[TB] FAIL underrun_stream len %0d stall %0d@%0d idx %0d got %h required %h",
                         n, sl, sa, diff, word_at(got, diff), word_at(exp, diff));
            end
            checks++;
            if (rdy != n + sl || d_cnt != 1) begin
                failures++;
                $display("[TB] FAIL underrun_ready tready %0d done %0d required %0d 1", rdy, d_cnt, n + sl);
            end
        end
    endtask

    task automatic test_reset_mid_fcs();
        byte_q_t data;
        word_q_t exp, got;
        int d_idx, d_cnt, rdy, gap, diff, n, target;
        bit to;
        n = $urandom_range(60, 80);
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        build_expected(data, 1'b1, -1, 0, exp);
        target = PRE_N + 1 + n + 1;
        sel = 1'b0;
        fork
            send_frame(data, -1, 0, 1'b1);
            begin
                int k;
                int guard;
                k = 0;
                guard = 0;
                while (m_txen !== 1'b1 && guard < 400) begin
                    @(negedge clk);
                    guard++;
                end
                while (m_txen === 1'b1 && k < target) begin
                    k++;
                    @(negedge clk);
                end
                checks++;
                if ({m_txer, m_txd} !== exp[target]) begin
                    failures++;
                    $display("[TB] FAIL rst_fcs_byte2 got %h required %h", {m_txer, m_txd}, exp[target]);
                end
                sresetn = 1'b0;
                @(negedge clk);
                checks++;
                if ({m_txd, m_txen, m_txer, m_busy, m_tready, m_done} !== 13'd0) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_fcs outputs got %h required 0",
                             {m_txd, m_txen, m_txer, m_busy, m_tready, m_done});
                end
                sresetn = 1'b1;
                repeat (3) @(negedge clk);
            end
        join
        data = {};
        n = $urandom_range(5, 70);
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        build_expected(data, 1'b1, -1, 0, exp);
        run_frame(1'b0, data, -1, 0, got, d_idx, d_cnt, rdy, gap, to);
        diff = first_diff(got, exp);
        checks++;
        if (to || diff != -1 || d_cnt != 1) begin
            failures++;
            $display("[TB] FAIL rst_recover len %0d idx %0d got %h required %h done %0d",
                     n, diff, word_at(got, diff), word_at(exp, diff), d_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_no_pad();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_reset_mid_fcs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation time limit reached, checks %0d failures %0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

endmodule
